ibis_tmds_rx: RTL and testbench

IBIS_TMDS_RX -- requirements
Module: ibis_tmds_rx

---
 rtl/ibis_tmds_rx.sv | 187 ++++++++++++++++++
 tb/tb_ibis_tmds_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibis_tmds_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ibis_tmds_rx
//  Brief    : Single-channel TMDS receiver. Hunts for control-token alignment
//             in a serial bitstream, verifies phase over several tokens, then
//             decodes aligned 10-bit symbols into video bytes or control codes.
//             A watchdog drops lock after too many consecutive video words.
//  Revision : 1.0 - initial release
// ============================================================================
module ibis_tmds_rx #(
  parameter int LOCK_COUNT     = 4,
  parameter int WATCHDOG_WORDS = 4096
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       enable,
  input  logic       in_serial,
  output logic       locked,
  output logic       out_valid,
  output logic       data_enable,
  output logic [1:0] control,
  output logic [7:0] data
);

  localparam int              WD_W       = $clog2(WATCHDOG_WORDS + 1);
  localparam logic [3:0]      LOCK_LIMIT = 4'(LOCK_COUNT);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(WATCHDOG_WORDS);
  localparam logic [WD_W-1:0] WD_ONE     = WD_W'(1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Control tokens as they appear in the shift register (sr[9] leftmost).
  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  logic [1:0]      state_q,  state_d;
  logic [9:0]      sr_q,     sr_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [3:0]      match_q,  match_d;
  logic [WD_W-1:0] wd_q,     wd_d;
  logic            valid_q,  valid_d;
  logic            de_q,     de_d;
  logic [1:0]      ctrl_q,   ctrl_d;
  logic [7:0]      data_q,   data_d;

  logic            w_is_tok;
  logic [1:0]      w_tok_val;
  logic [7:0]      w_vid_d;
  logic [7:0]      w_vid_byte;
  logic            w_boundary;
  logic [3:0]      w_bitcnt_inc;
  logic [3:0]      w_match_inc;
  logic [WD_W-1:0] w_wd_inc;

  assign w_boundary   = (bitcnt_q == 4'd0);
  assign w_bitcnt_inc = (bitcnt_q == 4'd9) ? 4'd0 : bitcnt_q + 4'd1;
  assign w_match_inc  = match_q + 4'd1;
  assign w_wd_inc     = wd_q + WD_ONE;

  // Classify the current shift-register contents as one of the four tokens.
  always_comb begin
    w_is_tok  = 1'b1;
    w_tok_val = 2'b00;
    case (sr_q)
      TOK_C00: w_tok_val = 2'b00;
      TOK_C01: w_tok_val = 2'b01;
      TOK_C10: w_tok_val = 2'b10;
      TOK_C11: w_tok_val = 2'b11;
      default: w_is_tok  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    w_vid_d       = sr_q[9] ? ~sr_q[7:0] : sr_q[7:0];
    w_vid_byte    = 8'h00;
    w_vid_byte[0] = w_vid_d[0];
    for (int i = 1; i < 8; i++) begin
      w_vid_byte[i] = sr_q[8] ? (w_vid_d[i] ^ w_vid_d[i-1])
                              : ~(w_vid_d[i] ^ w_vid_d[i-1]);
    end
  end

  // Alignment state machine, phase counter, watchdog and output decode.
  always_comb begin
    sr_d     = {in_serial, sr_q[9:1]};
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    match_d  = match_q;
    wd_d     = wd_q;
    valid_d  = 1'b0;
    de_d     = de_q;
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    case (state_q)
      ST_HUNT: begin
        if (w_is_tok) begin
          state_d  = ST_VERIFY;
          bitcnt_d = 4'd1;
          match_d  = 4'd1;
        end
      end
      ST_VERIFY: begin
        bitcnt_d = w_bitcnt_inc;
        if (w_boundary) begin
          if (w_is_tok) begin
            match_d = w_match_inc;
            if (w_match_inc == LOCK_LIMIT) begin
              state_d = ST_LOCKED;
              wd_d    = '0;
            end
          end else begin
            state_d  = ST_HUNT;
            match_d  = 4'd0;
            bitcnt_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        bitcnt_d = w_bitcnt_inc;
        if (w_boundary) begin
          if (w_is_tok) begin
            wd_d    = '0;
            valid_d = 1'b1;
            de_d    = 1'b0;
            ctrl_d  = w_tok_val;
          end else if (w_wd_inc == WD_LIMIT) begin
            // Too long without a token: abandon lock, drop this word.
            state_d  = ST_HUNT;
            wd_d     = '0;
            match_d  = 4'd0;
            bitcnt_d = 4'd0;
          end else begin
            wd_d    = w_wd_inc;
            valid_d = 1'b1;
            de_d    = 1'b1;
            data_d  = w_vid_byte;
          end
        end
      end
      default: begin
        state_d  = ST_HUNT;
        match_d  = 4'd0;
        bitcnt_d = 4'd0;
        wd_d     = '0;
      end
    endcase
  end

  // Register update; all state freezes while enable is low.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_HUNT;
      sr_q     <= 10'd0;
      bitcnt_q <= 4'd0;
      match_q  <= 4'd0;
      wd_q     <= '0;
      valid_q  <= 1'b0;
      de_q     <= 1'b0;
      ctrl_q   <= 2'b00;
      data_q   <= 8'h00;
    end else if (enable) begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      match_q  <= match_d;
      wd_q     <= wd_d;
      valid_q  <= valid_d;
      de_q     <= de_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
    end
  end

  // A pending strobe stays registered but is hidden until enable returns.
  assign out_valid   = valid_q & enable;
  assign locked      = (state_q == ST_LOCKED);
  assign data_enable = de_q;
  assign control     = ctrl_q;
  assign data        = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ibis_tmds_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibis_tmds_rx
//  Brief    : Directed self-checking bench for ibis_tmds_rx. Symbols are
//             hand-derived or produced by an 8b->10b TMDS encoder model so the
//             expected byte is always the value that was encoded.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibis_tmds_rx;

  localparam logic [9:0] T00   = 10'b1101010100;
  localparam logic [9:0] T01   = 10'b0010101011;
  localparam logic [9:0] T10   = 10'b0101010100;
  localparam logic [9:0] T11   = 10'b1010101011;
  localparam logic [9:0] V_00  = 10'b0100000000;  // XOR chain, no invert -> 0x00
  localparam logic [9:0] V_FF  = 10'b1000000000;  // inverted, XNOR chain -> 0xFF
  localparam logic [9:0] V_A5  = 10'b0101100011;  // q_m = 0x63, XOR      -> 0xA5
  localparam logic [9:0] V_A5N = 10'b1110011100;  // same, inverted       -> 0xA5

  logic       aclk;
  logic       areset;
  logic       enable;
  logic       in_serial;
  logic       locked;
  logic       out_valid;
  logic       data_enable;
  logic [1:0] control;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  ibis_tmds_rx #(
    .LOCK_COUNT     (4),
    .WATCHDOG_WORDS (16)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .enable      (enable),
    .in_serial   (in_serial),
    .locked      (locked),
    .out_valid   (out_valid),
    .data_enable (data_enable),
    .control     (control),
    .data        (data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count strobes on the falling edge, away from the active edge.
  always @(negedge aclk) begin
    if (out_valid === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_(input logic b);
    in_serial = b;
    enable    = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic sym_range(input logic [9:0] s, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) bit_(s[i]);
  endtask

  task automatic sym(input logic [9:0] s);
    sym_range(s, 0, 9);
  endtask

  // Reference 8b->10b TMDS video encoder; inv selects the DC-balance inversion.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
    logic [7:0] qm;
    int         n1;
    logic       use_xnor;
    n1       = $countones(d);
    use_xnor = (n1 > 4) || ((n1 == 4) && (d[0] == 1'b0));
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    return {inv, ~use_xnor, inv ? ~qm : qm};
  endfunction

  int         p0;
  int         offs [4];
  logic [7:0] bq   [4];

  initial begin
    areset    = 1'b1;
    enable    = 1'b0;
    in_serial = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    // Reset applies even with enable low.
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_de",     32'(data_enable), 32'd0);
    chk("rst_ctrl",   32'(control), 32'd0);
    chk("rst_data",   32'(data), 32'd0);
    areset = 1'b0;

    // ---- Lock on four ctrl-01 tokens, then video ----
    repeat (4) sym(T01);
    chk("lock_not_yet", 32'(locked), 32'd0);
    bit_(V_FF[0]);
    chk("lock_after_4th", 32'(locked), 32'd1);
    sym_range(V_FF, 1, 9);
    chk("lock_word_not_emitted", 32'(pulses), 32'd0);
    // Strobe two enabled cycles after the last symbol bit.
    bit_(V_00[0]);
    chk("lat_valid_hi", 32'(out_valid), 32'd1);
    chk("lat_de",       32'(data_enable), 32'd1);
    chk("lat_data_ff",  32'(data), 32'hFF);
    bit_(V_00[1]);
    chk("lat_valid_lo", 32'(out_valid), 32'd0);
    sym_range(V_00, 2, 9);
    sym(T11);
    chk("v00_data", 32'(data), 32'h00);
    chk("v00_de",   32'(data_enable), 32'd1);
    chk("v00_pulses", 32'(pulses), 32'd2);
    sym(V_FF);
    chk("t11_de",   32'(data_enable), 32'd0);
    chk("t11_ctrl", 32'(control), 32'd3);
    chk("t11_data_kept", 32'(data), 32'h00);

    // ---- Enable low for 7 cycles while a strobe is pending, mid-symbol ----
    bit_(V_A5[0]);
    enable = 1'b0;
    repeat (7) begin
      in_serial = ~in_serial;
      @(posedge aclk);
      #1;
    end
    chk("stall_valid_lo", 32'(out_valid), 32'd0);
    chk("stall_pulses",   32'(pulses), 32'd3);
    chk("stall_data",     32'(data), 32'hFF);
    chk("stall_locked",   32'(locked), 32'd1);
    in_serial = V_A5[1];
    enable    = 1'b1;
    #2;
    chk("deferred_valid_hi", 32'(out_valid), 32'd1);
    @(posedge aclk);
    #1;
    chk("deferred_valid_lo", 32'(out_valid), 32'd0);
    sym_range(V_A5, 2, 9);
    sym(T00);
    chk("stall_next_data", 32'(data), 32'hA5);
    chk("stall_pulses_after", 32'(pulses), 32'd5);
    sym(V_A5N);
    chk("t00_ctrl", 32'(control), 32'd0);
    chk("t00_de",   32'(data_enable), 32'd0);

    // ---- Watchdog: 16 video words after a token drops lock ----
    sym(T11);
    p0 = pulses;
    for (int i = 0; i < 16; i++) sym(tmds_enc(8'(i * 37 + 11), i[0]));
    chk("wd_still_locked", 32'(locked), 32'd1);
    bit_(1'b0);
    chk("wd_unlocked", 32'(locked), 32'd0);
    chk("wd_pulses", 32'(pulses - p0), 32'd16);
    chk("wd_data_last_emitted", 32'(data), 32'(8'(14 * 37 + 11)));
    chk("wd_ctrl", 32'(control), 32'd3);

    // ---- Leading bit offsets, encoder round trip, mid-operation reset ----
    offs[0] = 3;
    offs[1] = 7;
    offs[2] = 9;
    offs[3] = int'($urandom_range(0, 9));
    for (int n = 0; n < 4; n++) begin
      areset = 1'b1;
      bit_(1'b0);
      areset = 1'b0;
      for (int z = 0; z < offs[n]; z++) bit_(1'b0);
      repeat (4) sym(T01);
      for (int k = 0; k < 4; k++) begin
        bq[k] = 8'(k * 73 + offs[n] * 29 + 5);
        sym(tmds_enc(bq[k], k[0] ^ n[0]));
        if (k == 0) chk("off_locked", 32'(locked), 32'd1);
        else        chk("off_data", 32'(data), 32'(bq[k-1]));
      end
      sym(T10);
      chk("off_data_last", 32'(data), 32'(bq[3]));
      sym(T10);
      chk("off_ctrl", 32'(control), 32'd2);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      chk("mid_rst_locked", 32'(locked), 32'd0);
      chk("mid_rst_valid",  32'(out_valid), 32'd0);
      chk("mid_rst_de",     32'(data_enable), 32'd0);
      chk("mid_rst_ctrl",   32'(control), 32'd0);
      chk("mid_rst_data",   32'(data), 32'd0);
      areset = 1'b0;
    end

    // ---- Three tokens then video: falls back to hunting, no lock ----
    p0 = pulses;
    repeat (3) sym(T01);
    sym(V_FF);
    for (int z = 0; z < 12; z++) bit_(1'b0);
    chk("short_seq_unlocked", 32'(locked), 32'd0);
    chk("short_seq_no_valid", 32'(pulses - p0), 32'd0);
    repeat (4) sym(T01);
    bit_(1'b0);
    chk("relock_full_seq", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
